// File: rtl/pwm_multi_avalon.sv
// Multi-channel PWM generator with an Avalon-MM slave.
// Software programs a shared period and per-channel duty values into shadow
// registers; a commit moves the whole shadow set into the active set at a
// period boundary (or immediately while disabled), so outputs never see a
// half-updated configuration.
module pwm_multi_avalon #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam int         DUTY_BASE   = 4;

  // Control and status
  logic             en;
  logic             irq_en;
  logic             pending;
  logic             wrap_flag;

  // Shadow (software-visible) and active (in-use) configuration
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] duty_sh  [NUM_CH];
  logic [CNT_W-1:0] duty_act [NUM_CH];
  logic [CNT_W-1:0] cnt;

  logic              wr_en;
  logic              wr_ctrl;
  logic              wr_period;
  logic              wr_status;
  logic [NUM_CH-1:0] wr_duty;
  logic [CNT_W-1:0]  wdata_cnt;
  logic              commit;
  logic              en_next;
  logic              wrap;
  logic              xfer;
  logic [NUM_CH-1:0] pwm_next;

  // Upper writedata bits are architecturally ignored for counter-sized fields.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en & (address == ADDR_CTRL);
  assign wr_period = wr_en & (address == ADDR_PERIOD);
  assign wr_status = wr_en & (address == ADDR_STATUS);
  assign wdata_cnt = writedata[CNT_W-1:0];
  assign commit    = wr_ctrl & writedata[1];
  assign en_next   = wr_ctrl ? writedata[0] : en;

  // A wrap is the last cycle of a period; the shadow set moves over on a wrap
  // or straight away when the counter is idle.
  assign wrap = en & (cnt == period_act);
  assign xfer = pending & (wrap | ~en);
  assign irq  = wrap_flag & irq_en;

  // Decode per-channel duty writes and the next PWM output levels.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_duty  = '0;
    pwm_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_duty[i]  = wr_en & (address == 4'(DUTY_BASE + i));
      pwm_next[i] = en & (cnt < duty_act[i]);
    end
  end

  // Control, status and shadow period registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      period_sh <= '0;
      pending   <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= writedata[0];
        irq_en <= writedata[2];
      end
      if (wr_period) period_sh <= wdata_cnt;
      // A commit landing on a wrap edge re-arms for the following wrap.
      if (commit)    pending <= 1'b1;
      else if (xfer) pending <= 1'b0;
      // Hardware set takes priority over a same-edge software clear.
      if (wrap)                                wrap_flag <= 1'b1;
      else if (wr_status && writedata[1])      wrap_flag <= 1'b0;
    end
  end

  // Per-channel duty shadows.
  // NOTE: these register arrays are reset explicitly because software may
  // read them back before ever writing them; they are flops, not a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty[i]) duty_sh[i] <= wdata_cnt;
      end
    end
  end

  // Active set, period counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_act <= '0;
      cnt        <= '0;
      pwm_out    <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
    end else begin
      if (xfer) begin
        period_act <= period_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
      // Disabling clears the counter on the same edge; enabling starts at 0.
      if (!en || !en_next || wrap) cnt <= '0;
      else                         cnt <= cnt + CNT_W'(1);
      pwm_out <= pwm_next;
    end
  end

  // Zero-extended combinational read of the shadow registers.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0]       = {irq_en, 1'b0, en};
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_sh;
      ADDR_STATUS: readdata[1:0]       = {wrap_flag, pending};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == 4'(DUTY_BASE + i)) readdata[CNT_W-1:0] = duty_sh[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_multi_avalon.sv
// Self-checking bench for pwm_multi_avalon: register table, directed
// sequences for the period-boundary corner cases, and random traffic checked
// against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pwm_multi_avalon;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 20;
  localparam logic [31:0] MASK = 32'((64'd1 << CNT_W) - 1);

  logic              clk;
  logic              reset_n;
  logic [3:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] pwm_out;
  logic              irq;

  int checks = 0;
  int errors = 0;

  pwm_multi_avalon #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit                m_en, m_ie, m_pend, m_wf;
  int unsigned       m_per_sh, m_per, m_cnt;
  int unsigned       m_duty_sh [NUM_CH];
  int unsigned       m_duty    [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_pend = 0; m_wf = 0;
    m_per_sh = 0; m_per = 0; m_cnt = 0; m_pwm = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      m_duty_sh[n] = 0;
      m_duty[n]    = 0;
    end
  endtask

  // One rising edge of the model, computed from pre-edge state.
  task automatic model_edge(input bit w, input int a, input logic [31:0] d);
    bit wrap, xfer, en_after;
    wrap     = m_en && (m_cnt == m_per);
    xfer     = m_pend && (wrap || !m_en);
    en_after = (w && a == 0) ? d[0] : m_en;
    for (int n = 0; n < NUM_CH; n++) m_pwm[n] = m_en && (m_cnt < m_duty[n]);
    if (!m_en || !en_after || wrap) m_cnt = 0;
    else                            m_cnt = m_cnt + 1;
    if (xfer) begin
      m_per = m_per_sh;
      for (int n = 0; n < NUM_CH; n++) m_duty[n] = m_duty_sh[n];
    end
    if (w && a == 0 && d[1]) m_pend = 1;
    else if (xfer)           m_pend = 0;
    if (wrap)                     m_wf = 1;
    else if (w && a == 2 && d[1]) m_wf = 0;
    if (w) begin
      if (a == 0) begin
        m_en = d[0];
        m_ie = d[2];
      end else if (a == 1) begin
        m_per_sh = d & MASK;
      end else if (a >= 4 && a - 4 < NUM_CH) begin
        m_duty_sh[a-4] = d & MASK;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 0)      r = {29'd0, m_ie, 1'b0, m_en};
    else if (a == 1) r = m_per_sh;
    else if (a == 2) r = {30'd0, m_wf, m_pend};
    else if (a >= 4 && int'(a) - 4 < NUM_CH) r = m_duty_sh[int'(a) - 4];
    return r;
  endfunction

  // Drive one bus cycle (write or read), step the model, compare outputs.
  task automatic tick(input bit w, input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = !w;
    @(posedge clk);
    model_edge(w, int'(a), d);
    #1;
    check("pwm", 32'(pwm_out), 32'(m_pwm));
    check("irq", 32'(irq), 32'(m_wf & m_ie));
    check("rdata", readdata, m_read(address));
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(name, readdata, exp);
  endtask

  // Asynchronous reset between clock edges, then read every address back.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      tick(0, 4'(a), 32'd0);
      check("rst_read", readdata, 32'd0);
    end
  endtask

  // Poll STATUS until PENDING clears; exits right after the transfer edge.
  task automatic wait_clear(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(0, 4'd2, 32'd0);
      if (readdata[0] == 1'b0) done = 1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();

    vecs[0] = '{1'b1, 4'd1,  32'hFFFF_FFFF, 32'h000F_FFFF};
    vecs[1] = '{1'b1, 4'd4,  32'h0001_2345, 32'h0001_2345};
    vecs[2] = '{1'b1, 4'd7,  32'hFFFA_BCDE, 32'h000A_BCDE};
    vecs[3] = '{1'b1, 4'd8,  32'h0000_0055, 32'h0000_0000};
    vecs[4] = '{1'b1, 4'd3,  32'h0000_0077, 32'h0000_0000};
    vecs[5] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{1'b1, 4'd0,  32'h0000_0004, 32'h0000_0004};
    vecs[7] = '{1'b1, 4'd0,  32'h0000_00FA, 32'h0000_0000};
    vecs[8] = '{1'b0, 4'd2,  32'h0000_0000, 32'h0000_0001};

    do_reset();

    // Register map table
    foreach (vecs[i]) begin
      if (vecs[i].w) tick(1, vecs[i].a, vecs[i].d);
      rd_check("table", vecs[i].a, vecs[i].exp);
    end
    do_reset();

    // Basic PWM then atomic duty update: PERIOD=9, DUTY0=3 -> 3 high / 7 low.
    tick(1, 4'd1, 32'd9);
    tick(1, 4'd4, 32'd3);
    tick(1, 4'd5, 32'd0);
    tick(1, 4'd6, 32'd0);
    tick(1, 4'd7, 32'd0);
    tick(1, 4'd0, 32'h2);
    tick(0, 4'd2, 32'd0);
    check("idle_commit", 32'(readdata[0]), 32'd0);
    tick(1, 4'd0, 32'h1);
    for (int r = 1; r <= 50; r++) begin
      int duty;
      if (r == 21)      tick(1, 4'd4, 32'd7);
      else if (r == 26) tick(1, 4'd0, 32'h3);
      else              tick(0, 4'd2, 32'd0);
      duty = (r <= 30) ? 3 : 7;
      check("pwm0_shape", 32'(pwm_out[0]), 32'(((r - 1) % 10) < duty));
      check("pwm_other", 32'(pwm_out[3:1]), 32'd0);
      if (r != 21 && r != 26) check("pending", 32'(readdata[0]), 32'(r >= 26 && r < 30));
    end

    // Extremes: duty 0 is constant low, duty > period is constant high.
    tick(1, 4'd5, 32'd0);
    tick(1, 4'd6, 32'd10);
    tick(1, 4'd0, 32'h3);
    wait_clear("ext_commit");
    for (int i = 0; i < 20; i++) begin
      tick(0, 4'd2, 32'd0);
      check("ch1_low", 32'(pwm_out[1]), 32'd0);
      check("ch2_high", 32'(pwm_out[2]), 32'd1);
    end

    // PERIOD=0: wrap every cycle, and the set beats a same-edge clear.
    tick(1, 4'd1, 32'd0);
    tick(1, 4'd0, 32'h3);
    wait_clear("p0_commit");
    for (int i = 0; i < 4; i++) begin
      tick(1, 4'd2, 32'h2);
      check("wrap_set_wins", 32'(readdata[1]), 32'd1);
      check("p0_pwm0", 32'(pwm_out[0]), 32'd1);
    end

    // Interrupt: rises after the first wrap, clears by W1C, returns next wrap.
    tick(1, 4'd1, 32'd9);
    tick(1, 4'd0, 32'h3);
    wait_clear("irq_commit");
    tick(1, 4'd2, 32'h2);
    tick(1, 4'd0, 32'h5);
    check("irq_idle", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 4'd2, 32'd0);
      check("irq_first", 32'(irq), 32'(i == 7));
    end
    tick(1, 4'd2, 32'h2);
    check("irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick(0, 4'd2, 32'd0);
      check("irq_again", 32'(irq), 32'(i == 8));
    end

    // Collision: commit on the wrap edge waits one full period.
    tick(1, 4'd4, 32'd2);
    begin
      bit aligned;
      aligned = 0;
      for (int i = 0; i < 20 && !aligned; i++) begin
        if (m_en && m_cnt == m_per) aligned = 1;
        else tick(0, 4'd2, 32'd0);
      end
      check("coll_align", 32'(aligned), 32'd1);
    end
    tick(1, 4'd0, 32'h7);
    for (int k = 1; k <= 20; k++) begin
      tick(0, 4'd2, 32'd0);
      check("coll_pwm0", 32'(pwm_out[0]), 32'(((k - 1) % 10) < ((k <= 10) ? 7 : 2)));
      check("coll_pending", 32'(readdata[0]), 32'(k < 10));
    end

    // Reset while running.
    tick(0, 4'd2, 32'd0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic [3:0]  a;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      a = 4'($urandom_range(0, 15));
      if (r < 4) begin
        if (a == 0) begin
          d = 32'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end else if (a == 1) begin
          d = 32'($urandom_range(0, 12));
        end else if ($urandom_range(0, 7) == 0) begin
          d = $urandom;
        end else begin
          d = 32'($urandom_range(0, 14));
        end
        tick(1, a, d);
      end else begin
        tick(0, a, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
